imem_fetch_ctrl: RTL and testbench

IMEM_FETCH_CTRL -- requirements
Module: imem_fetch_ctrl

---
 rtl/imem_ctrl_pkg.sv | 21 ++
 rtl/fetch_fifo.sv | 52 +++++
 rtl/imem_fetch_ctrl.sv | 141 ++++++++++++++
 tb/tb_imem_fetch_ctrl.sv | 371 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_ctrl_pkg.sv
// Shared types and defaults for the instruction-memory fetch controller.
// Holds the FSM encoding and the pc wrap helper.
package imem_ctrl_pkg;

  localparam int          INSTR_W       = 32;
  localparam logic [31:0] RESET_PC_DEF  = 32'h0;
  localparam int          MEM_BYTES_DEF = 256;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1
  } state_t;

  function automatic logic [31:0] wrap_pc(
    input logic [31:0] a,
    input logic [31:0] lim
  );
    return (a >= lim) ? 32'h0 : a;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Two-entry FIFO holding {pc, instr} pairs between fetch and decode.
// Flush empties it in one cycle; storage resets to zero.
module fetch_fifo #(
  parameter int W = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         empty,
  output logic [1:0]   count
);

  logic [W-1:0] mem_q [2];
  logic         wr_q;
  logic         rd_q;
  logic [1:0]   cnt_q;
  logic         do_push;
  logic         do_pop;

  assign do_pop  = pop && (cnt_q != 2'd0);
  assign do_push = push && ((cnt_q != 2'd2) || do_pop);
  assign dout    = mem_q[rd_q];
  assign empty   = (cnt_q == 2'd0);
  assign count   = cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_q     <= 1'b0;
      rd_q     <= 1'b0;
      cnt_q    <= 2'd0;
    end else if (flush) begin
      wr_q  <= 1'b0;
      rd_q  <= 1'b0;
      cnt_q <= 2'd0;
    end else begin
      if (do_push) begin
        mem_q[wr_q] <= din;
        wr_q        <= ~wr_q;
      end
      if (do_pop) rd_q <= ~rd_q;
      cnt_q <= cnt_q + {1'b0, do_push}
                     - {1'b0, do_pop};
    end
  end

endmodule

// File: rtl/imem_fetch_ctrl.sv
// Instruction fetch controller: loads program words while idle,
// then streams fetched {pc, instr} to decode through a 2-deep FIFO.
module imem_fetch_ctrl
  import imem_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEF,
  parameter int          MEM_BYTES = MEM_BYTES_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               halt,
  input  logic               ld_valid,
  output logic               ld_ready,
  input  logic [31:0]        ld_addr,
  input  logic [INSTR_W-1:0] ld_data,
  input  logic               redir_valid,
  input  logic [31:0]        redir_pc,
  output logic               mem_en,
  output logic               mem_we,
  output logic [31:0]        mem_addr,
  output logic [INSTR_W-1:0] mem_wdata,
  input  logic [INSTR_W-1:0] mem_rdata,
  output logic               if_valid,
  input  logic               if_ready,
  output logic [31:0]        if_pc,
  output logic [INSTR_W-1:0] if_instr,
  output logic [1:0]         state
);

  localparam logic [31:0] MEM_LIM = 32'(MEM_BYTES);

  state_t      st_q;
  state_t      st_d;
  logic [31:0] pc_q;
  logic [31:0] pc_inc;
  logic [31:0] redir_tgt;
  logic [31:0] rd_pc_q;
  logic        pend_q;
  logic        rd_issue;
  logic        kill;
  logic        rsp_push;
  logic        pop;
  logic        f_empty;
  logic [1:0]  f_cnt;
  logic [2:0]  occ;
  logic [31+INSTR_W:0] f_dout;

  assign kill      = (st_q == RUN) && (halt || redir_valid);
  assign pc_inc    = wrap_pc(pc_q + 32'd4, MEM_LIM);
  assign redir_tgt = wrap_pc(redir_pc & ~32'h3, MEM_LIM);
  assign pop       = if_valid && if_ready;
  assign occ       = {1'b0, f_cnt} + {2'b00, pend_q};
  assign rsp_push  = pend_q && !kill;

  assign if_valid  = !f_empty;
  assign if_pc     = f_dout[31+INSTR_W:INSTR_W];
  assign if_instr  = f_dout[INSTR_W-1:0];
  assign state     = st_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) st_q <= IDLE;
    else     st_q <= st_d;
  end

  always_comb begin
    st_d = st_q;
    unique case (st_q)
      IDLE:    if (start) st_d = RUN;
      RUN:     if (halt)  st_d = IDLE;
      default: st_d = IDLE;
    endcase
  end

  // The first read issues in the start cycle itself; in RUN a
  // slot freed by this cycle's pop may be refilled immediately.
  always_comb begin
    ld_ready  = 1'b0;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    rd_issue  = 1'b0;
    if (!rst) begin
      unique case (st_q)
        IDLE: begin
          ld_ready = 1'b1;
          if (ld_valid) begin
            if (ld_addr < MEM_LIM) begin
              mem_en    = 1'b1;
              mem_we    = 1'b1;
              mem_addr  = ld_addr & ~32'h3;
              mem_wdata = ld_data;
            end
          end else if (start) begin
            rd_issue = 1'b1;
          end
        end
        RUN: rd_issue = !kill &&
               (occ < (3'd2 + {2'b00, pop}));
        default: ;
      endcase
      if (rd_issue) begin
        mem_en   = 1'b1;
        mem_addr = pc_q;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q    <= RESET_PC;
      pend_q  <= 1'b0;
      rd_pc_q <= '0;
    end else begin
      pend_q <= rd_issue;
      if (rd_issue) rd_pc_q <= pc_q;
      if (st_q == RUN && halt)
        pc_q <= RESET_PC;
      else if (st_q == RUN && redir_valid)
        pc_q <= redir_tgt;
      else if (rd_issue)
        pc_q <= pc_inc;
    end
  end

  fetch_fifo #(
    .W(32 + INSTR_W)
  ) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .flush(kill),
    .push (rsp_push),
    .din  ({rd_pc_q, mem_rdata}),
    .pop  (pop),
    .dout (f_dout),
    .empty(f_empty),
    .count(f_cnt)
  );

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Bench for imem_fetch_ctrl: queue-based fetch model checked every
// cycle, plus literal expectations for the directed scenarios.
module tb_imem_fetch_ctrl;

  localparam logic [31:0] RPC = 32'h0;
  localparam int          MB  = 256;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        halt;
  logic        ld_valid;
  logic        ld_ready;
  logic [31:0] ld_addr;
  logic [31:0] ld_data;
  logic        redir_valid;
  logic [31:0] redir_pc;
  logic        mem_en;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic [1:0]  state;

  always #5 clk = ~clk;

  imem_fetch_ctrl #(
    .RESET_PC (RPC),
    .MEM_BYTES(MB)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .halt       (halt),
    .ld_valid   (ld_valid),
    .ld_ready   (ld_ready),
    .ld_addr    (ld_addr),
    .ld_data    (ld_data),
    .redir_valid(redir_valid),
    .redir_pc   (redir_pc),
    .mem_en     (mem_en),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .if_valid   (if_valid),
    .if_ready   (if_ready),
    .if_pc      (if_pc),
    .if_instr   (if_instr),
    .state      (state)
  );

  // Physical memory driven only by the DUT's strobes.
  logic [31:0] ram [64];
  logic        mem_clr;
  always @(posedge clk) begin
    if (mem_clr)
      for (int i = 0; i < 64; i++) ram[i] <= '0;
    else if (mem_en && mem_we)
      ram[mem_addr[7:2]] <= mem_wdata;
    if (mem_en && !mem_we)
      mem_rdata <= ram[mem_addr[7:2]];
  end

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  // Reference model: mode, pc, buffered queue, one read in flight.
  int          mstate;
  logic [31:0] mpc;
  bit          infl;
  logic [31:0] infl_pc;
  logic [63:0] q[$];
  logic [31:0] mmem [64];
  bit          m_iss;
  bit          m_pop;

  function automatic logic [31:0] wrapm(input logic [31:0] a);
    return (a >= MB) ? 32'h0 : a;
  endfunction

  function automatic bit exp_issue();
    int held;
    if (rst) return 1'b0;
    if (mstate == 0) return !ld_valid && start;
    if (halt || redir_valid) return 1'b0;
    held = q.size() + int'(infl);
    if (q.size() > 0 && if_ready) held--;
    return held < 2;
  endfunction

  initial begin
    mstate  = 0;
    mpc     = RPC;
    infl    = 1'b0;
    infl_pc = '0;
    for (int i = 0; i < 64; i++) mmem[i] = '0;
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        mstate = 0;
        mpc    = RPC;
        infl   = 1'b0;
        q.delete();
      end else begin
        m_iss = exp_issue();
        m_pop = q.size() > 0 && if_ready;
        if (mstate == 0) begin
          if (ld_valid && ld_addr < MB)
            mmem[ld_addr[7:2]] = ld_data;
          infl = m_iss;
          if (m_iss) begin
            infl_pc = mpc;
            mpc     = wrapm(mpc + 4);
          end
          if (start) mstate = 1;
        end else if (halt) begin
          q.delete();
          infl   = 1'b0;
          mstate = 0;
          mpc    = RPC;
        end else if (redir_valid) begin
          q.delete();
          infl = 1'b0;
          mpc  = wrapm(redir_pc & ~32'h3);
        end else begin
          if (m_pop) void'(q.pop_front());
          if (infl)
            q.push_back({infl_pc, mmem[infl_pc[7:2]]});
          infl = m_iss;
          if (m_iss) begin
            infl_pc = mpc;
            mpc     = wrapm(mpc + 4);
          end
        end
      end
    end
  end

  logic [63:0] dlog[$];
  int          dcyc[$];
  bit          arm_first;
  int          first_valid_cyc = -1;
  bit          c_ev;
  bit          c_ei;
  bit          c_ew;

  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        chk("rst_state", state, 0);
        chk("rst_if_valid", if_valid, 0);
        chk("rst_mem_en", mem_en, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_bus", {mem_addr, mem_wdata}, 0);
        chk("rst_if_out", {if_pc, if_instr}, 0);
      end else begin
        c_ev = q.size() > 0;
        c_ei = exp_issue();
        c_ew = mstate == 0 && ld_valid && ld_addr < MB;
        chk("state", state, mstate);
        chk("ld_ready", ld_ready, mstate == 0);
        chk("if_valid", if_valid, c_ev);
        if (c_ev) chk("if_entry", {if_pc, if_instr}, q[0]);
        chk("mem_en", mem_en, c_ei || c_ew);
        chk("mem_we", mem_we, c_ew);
        if (c_ew)
          chk("mem_wr", {mem_addr, mem_wdata},
              {ld_addr & ~32'h3, ld_data});
        if (c_ei) chk("mem_rd_addr", mem_addr, mpc);
        if (if_valid && if_ready) begin
          dlog.push_back({if_pc, if_instr});
          dcyc.push_back(cyc);
        end
        if (arm_first && if_valid) begin
          first_valid_cyc = cyc;
          arm_first       = 1'b0;
        end
      end
    end
  end

  function automatic logic [63:0] dl(input int i);
    return (i < dlog.size()) ? dlog[i] : {64{1'b1}};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [31:0] a,
                      input logic [31:0] d);
    ld_valid = 1'b1;
    ld_addr  = a;
    ld_data  = d;
    tick();
    ld_valid = 1'b0;
  endtask

  task automatic redirect(input logic [31:0] t);
    redir_valid = 1'b1;
    redir_pc    = t;
    tick();
    redir_valid = 1'b0;
    dlog.delete();
    dcyc.delete();
  endtask

  int start_cyc;
  int nm;

  initial begin
    rst = 1'b1; start = 1'b0; halt = 1'b0;
    ld_valid = 1'b0; ld_addr = '0; ld_data = '0;
    redir_valid = 1'b0; redir_pc = '0; if_ready = 1'b0;
    mem_clr = 1'b1; arm_first = 1'b0;
    #1;
    chk("por_state", state, 0);
    chk("por_if_valid", if_valid, 0);
    repeat (2) tick();
    rst = 1'b0;
    mem_clr = 1'b0;
    #1;
    chk("ld_ready_after_rst", ld_ready, 1);
    tick();

    load(32'h00, 32'h00000013);
    load(32'h04, 32'h019806B3);
    load(32'h08, 32'h40340293);
    load(32'h0C, 32'h0000000C);
    load(32'h2C, 32'hAAAA002C);
    load(32'hF8, 32'h555500F8);
    load(32'hFC, 32'h111100FC);
    load(32'h100, 32'h00000BAD);

    // in-order stream at full rate
    if_ready = 1'b1;
    start = 1'b1;
    start_cyc = cyc;
    arm_first = 1'b1;
    tick();
    start = 1'b0;
    repeat (5) tick();
    chk("A_first_valid_lat", first_valid_cyc, start_cyc + 2);
    chk("A_d0", dl(0), {32'h0, 32'h00000013});
    chk("A_d1", dl(1), {32'h4, 32'h019806B3});
    chk("A_d2", dl(2), {32'h8, 32'h40340293});
    chk("A_consec", dcyc.size() >= 3 &&
        dcyc[1] == dcyc[0] + 1 && dcyc[2] == dcyc[0] + 2, 1);
    halt = 1'b1;
    tick();
    halt = 1'b0;
    tick();

    // back-pressure then release
    dlog.delete();
    dcyc.delete();
    if_ready = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (5) tick();
    chk("B_no_issue_full", mem_en, 0);
    chk("B_hold", {31'b0, if_valid, if_pc}, {32'h1, 32'h0});
    if_ready = 1'b1;
    repeat (3) tick();
    chk("B_count", dlog.size(), 3);
    chk("B_d0", dl(0), {32'h0, 32'h00000013});
    chk("B_d1", dl(1), {32'h4, 32'h019806B3});
    chk("B_d2", dl(2), {32'h8, 32'h40340293});
    halt = 1'b1;
    tick();
    halt = 1'b0;

    // redirect while 0x08 is in flight
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (2) tick();
    redirect(32'h2C);
    repeat (4) tick();
    chk("C_redir_first", dl(0), {32'h2C, 32'hAAAA002C});
    chk("C_redir_next", dl(1), {32'h30, 32'h0});
    redirect(32'h2E);
    repeat (4) tick();
    chk("C_unaligned", dl(0), {32'h2C, 32'hAAAA002C});
    redirect(32'hF8);
    repeat (5) tick();
    chk("C_wrap0", dl(0), {32'hF8, 32'h555500F8});
    chk("C_wrap1", dl(1), {32'hFC, 32'h111100FC});
    chk("C_wrap2", dl(2), {32'h00, 32'h00000013});
    redirect(32'h104);
    repeat (4) tick();
    chk("C_oor_redir", dl(0), {32'h00, 32'h00000013});

    // halt beats redirect
    halt = 1'b1;
    redir_valid = 1'b1;
    redir_pc = 32'h40;
    tick();
    halt = 1'b0;
    redir_valid = 1'b0;
    chk("D_state_idle", state, 0);
    chk("D_if_valid", if_valid, 0);
    chk("D_ld_ready", ld_ready, 1);
    redir_valid = 1'b1;
    redir_pc = 32'h40;
    tick();
    redir_valid = 1'b0;
    dlog.delete();
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (3) tick();
    chk("D_idle_redir_ign", dl(0), {32'h0, 32'h00000013});
    ld_valid = 1'b1;
    ld_addr = 32'h0;
    ld_data = 32'hDEADBEEF;
    #1;
    chk("D_ld_ready_run", ld_ready, 0);
    tick();
    ld_valid = 1'b0;

    // reset with a full buffer
    if_ready = 1'b0;
    repeat (4) tick();
    chk("E_buffered", if_valid, 1);
    rst = 1'b1;
    #1;
    chk("E_rst_valid", if_valid, 0);
    chk("E_rst_state", state, 0);
    tick();
    rst = 1'b0;
    dlog.delete();
    if_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    chk("E_restart_pc", dl(0), {RPC, 32'h00000013});

    chk("mem_word0", ram[0], 32'h00000013);
    nm = 0;
    for (int i = 0; i < 64; i++)
      if (ram[i] !== mmem[i]) nm++;
    chk("mem_image", nm, 0);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
